// File: rtl/pipe_pkg.sv
// Shared types and constants for the 6-stage pipeline hazard/forwarding control.
package pipe_pkg;

    // Register indices are carried at this fixed width inside stage records; AW must not exceed it.
    localparam int unsigned REG_AW_MAX = 8;

    localparam int unsigned NSTAGE  = 4;
    localparam int unsigned STG_RR  = 0;
    localparam int unsigned STG_EX  = 1;
    localparam int unsigned STG_MEM = 2;
    localparam int unsigned STG_WB  = 3;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic                  valid;
        logic                  regwrite;
        logic                  is_load;
        logic [REG_AW_MAX-1:0] dst;
        logic [REG_AW_MAX-1:0] rs;
        logic [REG_AW_MAX-1:0] rt;
        logic                  use_rs;
        logic                  use_rt;
    } stage_rec_t;

    // MEM result is newest, but a load in MEM has no data yet, so fall back to WB.
    function automatic fwd_sel_t fwd_pick(input logic mem_hit, input logic mem_is_load,
                                          input logic wb_hit);
        fwd_sel_t sel;
        sel = FWD_NONE;
        if (mem_hit && !mem_is_load) begin
            sel = FWD_EXMEM;
        end else if (wb_hit) begin
            sel = FWD_MEMWB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipe_hazard_unit_match.sv
// Compares one in-flight writer against one source operand; $0 and unused sources never match.
module hazard_match
    import pipe_pkg::*;
(
    input  logic                  wr_en,
    input  logic [REG_AW_MAX-1:0] dst,
    input  logic [REG_AW_MAX-1:0] src,
    input  logic                  use_src,
    output logic                  match_c
);

    assign match_c = wr_en && use_src && (src != '0) && (dst == src);

endmodule

// File: rtl/pipe_hazard_unit.sv
// Interlock and forwarding control: tracks writers in RR..WB, stalls ID on hazards,
// selects RR bypass / EX forwarding, squashes IF/ID on jumps, counts stall/flush events.
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int unsigned NREG   = 32,
    parameter int unsigned AW     = $clog2(NREG),
    parameter bit          FWD_EN = 1'b1,
    parameter int unsigned CW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic [AW-1:0] id_dst,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic          id_jump,
    output logic          stall,
    output logic          flush_ifid,
    output logic          rr_byp_a,
    output logic          rr_byp_b,
    output logic [1:0]    ex_fwd_a,
    output logic [1:0]    ex_fwd_b,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] flush_cnt
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    stage_rec_t            slot_q [NSTAGE];
    stage_rec_t            id_rec;
    logic [REG_AW_MAX-1:0] id_src [2];
    logic [REG_AW_MAX-1:0] ex_src [2];
    logic [REG_AW_MAX-1:0] rr_src [2];
    logic                  id_use [2];
    logic                  ex_use [2];
    logic                  rr_use [2];
    logic [1:0]            hit_id_rr;
    logic [1:0]            hit_id_ex;
    logic [1:0]            hit_id_mem;
    logic [1:0]            hit_ex_mem;
    logic [1:0]            hit_ex_wb;
    logic [1:0]            hit_rr_wb;
    logic                  load_use;
    logic                  any_hit;

    always_comb begin
        id_rec          = '0;
        id_rec.valid    = id_valid;
        id_rec.regwrite = id_regwrite;
        id_rec.is_load  = id_memread;
        id_rec.dst      = REG_AW_MAX'(id_dst);
        id_rec.rs       = REG_AW_MAX'(id_rs);
        id_rec.rt       = REG_AW_MAX'(id_rt);
        id_rec.use_rs   = id_use_rs;
        id_rec.use_rt   = id_use_rt;
    end

    assign id_src[0] = REG_AW_MAX'(id_rs);
    assign id_src[1] = REG_AW_MAX'(id_rt);
    assign id_use[0] = id_use_rs;
    assign id_use[1] = id_use_rt;
    assign ex_src[0] = slot_q[STG_EX].rs;
    assign ex_src[1] = slot_q[STG_EX].rt;
    assign ex_use[0] = slot_q[STG_EX].use_rs;
    assign ex_use[1] = slot_q[STG_EX].use_rt;
    assign rr_src[0] = slot_q[STG_RR].rs;
    assign rr_src[1] = slot_q[STG_RR].rt;
    assign rr_use[0] = slot_q[STG_RR].use_rs;
    assign rr_use[1] = slot_q[STG_RR].use_rt;

    // Index 0 is the rs/A operand, index 1 is the rt/B operand.
    for (genvar k = 0; k < 2; k++) begin : g_src
        hazard_match u_id_rr (
            .wr_en(slot_q[STG_RR].valid && slot_q[STG_RR].regwrite), .dst(slot_q[STG_RR].dst),
            .src(id_src[k]), .use_src(id_use[k]), .match_c(hit_id_rr[k]));
        hazard_match u_id_ex (
            .wr_en(slot_q[STG_EX].valid && slot_q[STG_EX].regwrite), .dst(slot_q[STG_EX].dst),
            .src(id_src[k]), .use_src(id_use[k]), .match_c(hit_id_ex[k]));
        hazard_match u_id_mem (
            .wr_en(slot_q[STG_MEM].valid && slot_q[STG_MEM].regwrite), .dst(slot_q[STG_MEM].dst),
            .src(id_src[k]), .use_src(id_use[k]), .match_c(hit_id_mem[k]));
        hazard_match u_ex_mem (
            .wr_en(slot_q[STG_MEM].valid && slot_q[STG_MEM].regwrite), .dst(slot_q[STG_MEM].dst),
            .src(ex_src[k]), .use_src(ex_use[k]), .match_c(hit_ex_mem[k]));
        hazard_match u_ex_wb (
            .wr_en(slot_q[STG_WB].valid && slot_q[STG_WB].regwrite), .dst(slot_q[STG_WB].dst),
            .src(ex_src[k]), .use_src(ex_use[k]), .match_c(hit_ex_wb[k]));
        hazard_match u_rr_wb (
            .wr_en(slot_q[STG_WB].valid && slot_q[STG_WB].regwrite), .dst(slot_q[STG_WB].dst),
            .src(rr_src[k]), .use_src(rr_use[k]), .match_c(hit_rr_wb[k]));
    end

    // Stall and flush respond in the same cycle as the ID inputs.
    always_comb begin
        load_use   = (|hit_id_rr) && slot_q[STG_RR].is_load;
        any_hit    = (|hit_id_rr) || (|hit_id_ex) || (|hit_id_mem);
        stall      = id_valid && (FWD_EN ? load_use : any_hit);
        flush_ifid = id_valid && id_jump && !stall;
    end

    always_comb begin
        ex_fwd_a = FWD_NONE;
        ex_fwd_b = FWD_NONE;
        rr_byp_a = 1'b0;
        rr_byp_b = 1'b0;
        if (FWD_EN) begin
            ex_fwd_a = fwd_pick(hit_ex_mem[0], slot_q[STG_MEM].is_load, hit_ex_wb[0]);
            ex_fwd_b = fwd_pick(hit_ex_mem[1], slot_q[STG_MEM].is_load, hit_ex_wb[1]);
            rr_byp_a = hit_rr_wb[0];
            rr_byp_b = hit_rr_wb[1];
        end
    end

    // Writer records advance one stage per clock; a held ID instruction leaves a bubble in RR.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q    <= '{default: '0};
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            slot_q[STG_WB]  <= slot_q[STG_MEM];
            slot_q[STG_MEM] <= slot_q[STG_EX];
            slot_q[STG_EX]  <= slot_q[STG_RR];
            slot_q[STG_RR]  <= (id_valid && !stall) ? id_rec : '0;
            if (stall && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CW'(1);
            end
            if (flush_ifid && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Scoreboard bench: one DUT per forwarding mode, shared instruction stream, age-based reference model.
module tb_pipe_hazard_unit;

    localparam int unsigned CW      = 5;
    localparam int unsigned CNT_MAX = (1 << CW) - 1;
    localparam int unsigned RUN_MAX = 5000;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
        logic       use_rs;
        logic       use_rt;
        logic       regwrite;
        logic       memread;
        logic       jump;
    } ins_t;

    typedef struct packed {
        logic [31:0] cyc;
        ins_t        ins;
    } hist_t;

    typedef struct packed {
        logic          stall;
        logic          flush;
        logic          byp_a;
        logic          byp_b;
        logic [1:0]    fwd_a;
        logic [1:0]    fwd_b;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    localparam ins_t NOP = '0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          id_valid    [2];
    logic [4:0]    id_rs       [2];
    logic [4:0]    id_rt       [2];
    logic          id_use_rs   [2];
    logic          id_use_rt   [2];
    logic [4:0]    id_dst      [2];
    logic          id_regwrite [2];
    logic          id_memread  [2];
    logic          id_jump     [2];
    logic          stall_o     [2];
    logic          flush_o     [2];
    logic          byp_a_o     [2];
    logic          byp_b_o     [2];
    logic [1:0]    fwd_a_o     [2];
    logic [1:0]    fwd_b_o     [2];
    logic [CW-1:0] sc_o        [2];
    logic [CW-1:0] fc_o        [2];

    ins_t        prog [$];
    hist_t       hist0 [$];
    hist_t       hist1 [$];
    exp_t        expq0 [$];
    exp_t        expq1 [$];
    int unsigned pc [2];
    int unsigned sc_m [2];
    int unsigned fc_m [2];
    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    // Instance 0 is full interlock, instance 1 forwards.
    for (genvar m = 0; m < 2; m++) begin : g_dut
        pipe_hazard_unit #(.NREG(32), .FWD_EN(m == 1), .CW(CW)) u_dut (
            .clk(clk), .rst(rst),
            .id_valid(id_valid[m]), .id_rs(id_rs[m]), .id_rt(id_rt[m]),
            .id_use_rs(id_use_rs[m]), .id_use_rt(id_use_rt[m]), .id_dst(id_dst[m]),
            .id_regwrite(id_regwrite[m]), .id_memread(id_memread[m]), .id_jump(id_jump[m]),
            .stall(stall_o[m]), .flush_ifid(flush_o[m]),
            .rr_byp_a(byp_a_o[m]), .rr_byp_b(byp_b_o[m]),
            .ex_fwd_a(fwd_a_o[m]), .ex_fwd_b(fwd_b_o[m]),
            .stall_cnt(sc_o[m]), .flush_cnt(fc_o[m]));
    end

    function automatic ins_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                                input logic urs, input logic urt, input logic rw,
                                input logic mr, input logic j);
        ins_t i;
        i = '0;
        i.valid = 1'b1; i.rs = rs; i.rt = rt; i.dst = dst;
        i.use_rs = urs; i.use_rt = urt; i.regwrite = rw; i.memread = mr; i.jump = j;
        return i;
    endfunction

    // Does the instruction that left ID d cycles ago write register r?  ld reports if it is a load.
    function automatic logic writes(input hist_t h[$], input int unsigned c, input int unsigned d,
                                    input logic [4:0] r, output logic ld);
        logic hit;
        hit = 1'b0;
        ld  = 1'b0;
        if (r != 5'd0) begin
            foreach (h[i]) begin
                if ((c - h[i].cyc == d) && h[i].ins.regwrite && (h[i].ins.dst == r)) begin
                    hit = 1'b1;
                    ld  = h[i].ins.memread;
                end
            end
        end
        return hit;
    endfunction

    function automatic logic at_age(input hist_t h[$], input int unsigned c, input int unsigned d,
                                    output ins_t ins);
        logic found;
        found = 1'b0;
        ins   = NOP;
        foreach (h[i]) begin
            if (c - h[i].cyc == d) begin
                found = 1'b1;
                ins   = h[i].ins;
            end
        end
        return found;
    endfunction

    function automatic logic [1:0] ex_sel(input hist_t h[$], input int unsigned c,
                                          input logic [4:0] r, input logic u);
        logic       m_hit, w_hit, m_ld, w_ld;
        logic [1:0] sel;
        sel = 2'd0;
        if (u) begin
            m_hit = writes(h, c, 3, r, m_ld);
            w_hit = writes(h, c, 4, r, w_ld);
            if (m_hit && !m_ld) sel = 2'd1;
            else if (w_hit)     sel = 2'd2;
        end
        return sel;
    endfunction

    // Ages: 1 = RR, 2 = EX, 3 = MEM, 4 = WB.
    function automatic exp_t model(input hist_t h[$], input int unsigned c, input ins_t id,
                                   input logic fwd, input int unsigned sc, input int unsigned fc);
        exp_t       e;
        ins_t       ex_i, rr_i;
        logic [4:0] r;
        logic       u, hit, ld;
        e = '0;
        for (int k = 0; k < 2; k++) begin
            r = (k == 1) ? id.rt : id.rs;
            u = (k == 1) ? id.use_rt : id.use_rs;
            if (id.valid && u) begin
                if (fwd) begin
                    hit = writes(h, c, 1, r, ld);
                    if (hit && ld) e.stall = 1'b1;
                end else begin
                    for (int unsigned d = 1; d <= 3; d++) begin
                        hit = writes(h, c, d, r, ld);
                        if (hit) e.stall = 1'b1;
                    end
                end
            end
        end
        e.flush = id.valid && id.jump && !e.stall;
        if (fwd) begin
            if (at_age(h, c, 2, ex_i)) begin
                e.fwd_a = ex_sel(h, c, ex_i.rs, ex_i.use_rs);
                e.fwd_b = ex_sel(h, c, ex_i.rt, ex_i.use_rt);
            end
            if (at_age(h, c, 1, rr_i)) begin
                hit = writes(h, c, 4, rr_i.rs, ld);
                e.byp_a = rr_i.use_rs && hit;
                hit = writes(h, c, 4, rr_i.rt, ld);
                e.byp_b = rr_i.use_rt && hit;
            end
        end
        e.sc = CW'(sc);
        e.fc = CW'(fc);
        return e;
    endfunction

    task automatic check(input string name, input int m, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s fwd_en=%0d cycle=%0d: got %0d expected %0d", name, m, cyc, act, exp);
        end
    endtask

    task automatic compare(input int m, input exp_t e);
        check("stall",      m, int'(stall_o[m]), int'(e.stall));
        check("flush_ifid", m, int'(flush_o[m]), int'(e.flush));
        check("rr_byp_a",   m, int'(byp_a_o[m]), int'(e.byp_a));
        check("rr_byp_b",   m, int'(byp_b_o[m]), int'(e.byp_b));
        check("ex_fwd_a",   m, int'(fwd_a_o[m]), int'(e.fwd_a));
        check("ex_fwd_b",   m, int'(fwd_b_o[m]), int'(e.fwd_b));
        check("stall_cnt",  m, int'(sc_o[m]),    int'(e.sc));
        check("flush_cnt",  m, int'(fc_o[m]),    int'(e.fc));
    endtask

    // Monitor: compares whatever the driver predicted for this cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (expq0.size() > 0) compare(0, expq0.pop_front());
            if (expq1.size() > 0) compare(1, expq1.pop_front());
        end
    end

    // One clock of stimulus for both DUTs; a stalled instruction is re-presented next cycle.
    task automatic step(input logic r);
        ins_t  cur;
        exp_t  e;
        hist_t ent;
        hist_t h [$];
        @(posedge clk);
        #1;
        rst = r;
        cyc++;
        for (int m = 0; m < 2; m++) begin
            cur = (pc[m] < prog.size()) ? prog[pc[m]] : NOP;
            id_valid[m] = cur.valid;   id_rs[m] = cur.rs;         id_rt[m] = cur.rt;
            id_use_rs[m] = cur.use_rs; id_use_rt[m] = cur.use_rt; id_dst[m] = cur.dst;
            id_regwrite[m] = cur.regwrite; id_memread[m] = cur.memread; id_jump[m] = cur.jump;
            if (m == 0) h = hist0; else h = hist1;
            if (r) begin
                h.delete();
                sc_m[m] = 0;
                fc_m[m] = 0;
            end else begin
                e = model(h, cyc, cur, m == 1, sc_m[m], fc_m[m]);
                if (m == 0) expq0.push_back(e); else expq1.push_back(e);
                if (e.stall && sc_m[m] < CNT_MAX) sc_m[m]++;
                if (e.flush && fc_m[m] < CNT_MAX) fc_m[m]++;
                if (!e.stall) begin
                    if (cur.valid) begin
                        ent.cyc = cyc;
                        ent.ins = cur;
                        h.push_back(ent);
                    end
                    if (pc[m] < prog.size()) pc[m]++;
                end
                while (h.size() > 0 && (cyc - h[0].cyc >= 4)) void'(h.pop_front());
            end
            if (m == 0) hist0 = h; else hist1 = h;
        end
    endtask

    task automatic run_prog();
        int unsigned n;
        n = 0;
        while ((pc[0] < prog.size() || pc[1] < prog.size()) && n < RUN_MAX) begin
            step(1'b0);
            n++;
        end
        checks++;
        if (n >= RUN_MAX) begin
            errors++;
            $display("FAIL run_bound: got %0d cycles required below %0d", n, RUN_MAX);
            pc[0] = prog.size();
            pc[1] = prog.size();
        end
        repeat (5) step(1'b0);
    endtask

    task automatic add_nops(input int n);
        for (int i = 0; i < n; i++) prog.push_back(NOP);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        pc[0] = 0; pc[1] = 0; sc_m[0] = 0; sc_m[1] = 0; fc_m[0] = 0; fc_m[1] = 0;
        for (int m = 0; m < 2; m++) begin
            id_valid[m] = 1'b0; id_rs[m] = '0; id_rt[m] = '0; id_use_rs[m] = 1'b0;
            id_use_rt[m] = 1'b0; id_dst[m] = '0; id_regwrite[m] = 1'b0;
            id_memread[m] = 1'b0; id_jump[m] = 1'b0;
        end
        step(1'b1);
        step(1'b1);
        repeat (3) step(1'b0);

        // lw $5; add $6,$5,$5
        prog.push_back(mk(5'd1, 5'd0, 5'd5, 1, 0, 1, 1, 0));
        prog.push_back(mk(5'd5, 5'd5, 5'd6, 1, 1, 1, 0, 0));
        add_nops(4);
        // add $3; sub $4,$3,$1
        prog.push_back(mk(5'd1, 5'd2, 5'd3, 1, 1, 1, 0, 0));
        prog.push_back(mk(5'd3, 5'd1, 5'd4, 1, 1, 1, 0, 0));
        add_nops(4);
        // writer $7, two independents, reader of $7
        prog.push_back(mk(5'd1, 5'd2, 5'd7, 1, 1, 1, 0, 0));
        prog.push_back(mk(5'd11, 5'd12, 5'd10, 1, 1, 1, 0, 0));
        prog.push_back(mk(5'd11, 5'd12, 5'd13, 1, 1, 1, 0, 0));
        prog.push_back(mk(5'd7, 5'd7, 5'd14, 1, 1, 1, 0, 0));
        add_nops(4);
        // add $2; or $8,$2,$0; then a write to $0 followed by a $0 reader
        prog.push_back(mk(5'd1, 5'd1, 5'd2, 1, 1, 1, 0, 0));
        prog.push_back(mk(5'd2, 5'd0, 5'd8, 1, 1, 1, 0, 0));
        prog.push_back(mk(5'd1, 5'd1, 5'd0, 1, 1, 1, 0, 0));
        prog.push_back(mk(5'd0, 5'd0, 5'd8, 1, 1, 1, 0, 0));
        add_nops(4);
        // lw $5; jr $5
        prog.push_back(mk(5'd1, 5'd0, 5'd5, 1, 0, 1, 1, 0));
        prog.push_back(mk(5'd5, 5'd0, 5'd0, 1, 0, 0, 0, 1));
        add_nops(4);
        run_prog();

        for (int i = 0; i < int'(CNT_MAX) + 4; i++) begin
            prog.push_back(mk(5'd1, 5'd0, 5'd5, 1, 0, 1, 1, 0));
            prog.push_back(mk(5'd5, 5'd5, 5'd6, 1, 1, 1, 0, 0));
        end
        run_prog();
        @(negedge clk);
        for (int m = 0; m < 2; m++) check("stall_cnt_saturated", m, int'(sc_o[m]), int'(CNT_MAX));

        // Reset while a load-use stall is pending.
        prog.push_back(mk(5'd1, 5'd0, 5'd5, 1, 0, 1, 1, 0));
        prog.push_back(mk(5'd5, 5'd5, 5'd6, 1, 1, 1, 0, 0));
        step(1'b0);
        step(1'b1);
        run_prog();

        for (int i = 0; i < 400; i++) begin
            ins_t ri;
            ri          = mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                             5'($urandom_range(0, 7)),
                             $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 60,
                             $urandom_range(0, 99) < 70, 1'b0, $urandom_range(0, 99) < 8);
            ri.memread  = ri.regwrite && ($urandom_range(0, 99) < 35);
            ri.valid    = $urandom_range(0, 99) < 85;
            prog.push_back(ri);
        end
        run_prog();

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Scoreboard-based interlock and forwarding controller for the 6-stage MIPS pipeline (IF, ID, RR, EX, MEM, WB).
- Tracks every in-flight register writer from RR through WB.
- Stalls the front end on unresolvable hazards and drives operand-forwarding selects for RR and EX.
- Squashes IF/ID on jumps.
- Parametrised in register count and forwarding mode, replacing the hazard-free pipeline behaviour. Sits beside the pipeline registers and the processor datapath; holds control state only, no data.

## Interface
Parameters:
- NREG, 32, architectural register count; register 0 is hard-wired zero and never a hazard source.
- AW, $clog2(NREG), register index width.
- FWD_EN, 1, 1 = forwarding plus load-use stall; 0 = full interlock, no forwarding.
- CW, 16, width of the saturating performance counters.

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  valid instruction in ID
- id_rs, id_rt  in  AW  source registers of ID instruction
- id_use_rs, id_use_rt  in  1  source actually read
- id_dst  in  AW  destination after RegDst selection
- id_regwrite, id_memread, id_jump  in  1  decoded controls
- stall  out  1  hold PC, IF/ID, ID/RR; inject bubble into RR
- flush_ifid  out  1  squash IF/ID contents next edge
- rr_byp_a, rr_byp_b  out  1  RR stage: take WB write data instead of reg-file read
- ex_fwd_a, ex_fwd_b  out  2  EX operand select: 0 RR/EX value, 1 EX/MEM result, 2 MEM/WB write data
- stall_cnt, flush_cnt  out  CW  saturating event counters

## Operation
- Writer record per stage slot RR, EX, MEM, WB: {valid, dst, is_load, rs, rt, use_rs, use_rt}.
- Slots shift every clock: WB<=MEM, MEM<=EX, EX<=RR.
- RR<=ID record when id_valid && !stall; otherwise a bubble (valid=0).
- Match(slot, r) = slot.valid && slot.regwrite && slot.dst==r && r!=0, with the source's use bit set.
- FWD_EN=1:
  - stall = id_valid && Match(RR, src) && RR.is_load, for either used source (load-use, one cycle).
  - ex_fwd_x = 1 if Match(MEM, EX.src) && !MEM.is_load; else 2 if Match(WB, EX.src); else 0. MEM has priority over WB.
  - rr_byp_x = Match(WB, RR.src).
- FWD_EN=0:
  - stall = id_valid && Match(slot, src) for any slot in {RR, EX, MEM}, for either used source.
  - All forwarding outputs held at 0.
- flush_ifid = id_valid && id_jump && !stall. A stalled jump flushes only on the cycle it leaves ID.
- stall_cnt increments on each stall cycle; flush_cnt on each flush_ifid cycle; both saturate at 2^CW-1.
- Simultaneous load-use stall and jump in ID: stall wins, flush deferred.

## Timing
- stall, flush_ifid: combinational from ID inputs and registered slots. Same-cycle response, no latency.
- rr_byp_x, ex_fwd_x: combinational from registered slots only. No input-to-output path.
- Slots and counters update on rising clk.
- Reset: all slots invalid, counters 0, so every output is 0 in the cycle after rst.
- rst asserted mid-stall: the next cycle has no stall and empty slots. The datapath is responsible for its own pipeline-register clears.
- Load-use costs exactly 1 bubble with FWD_EN=1.
- With FWD_EN=0, a dependent instruction directly behind a writer stalls 3 cycles.

## Structure
- Shared package `pipe_pkg`:
  - stage-record typedef
  - ex_fwd encodings FWD_NONE=0, FWD_EXMEM=1, FWD_MEMWB=2
  - stage index constants
- One sub-module `hazard_match`: slot-vs-source comparator including the r!=0 and use-bit qualification, instanced per slot and per source.
- Counters and shift logic stay in the top.

## Test plan
- Reset with rst=1 for 2 cycles, then id_valid=0 -> all outputs 0, counters 0.
- FWD_EN=1, `lw $5` then `add $6,$5,$5` -> stall=1 for exactly 1 cycle; when add reaches EX, ex_fwd_a=ex_fwd_b=2; stall_cnt=1.
- FWD_EN=1, `add $3,...` then `sub $4,$3,$1` -> no stall; ex_fwd_a=1, ex_fwd_b=0 while sub is in EX.
- FWD_EN=1, writer $7 then two independent instructions then reader of $7 -> rr_byp=1 while the reader is in RR; ex_fwd=0.
- FWD_EN=0, `add $2,...` then `or $8,$2,$0` -> stall 3 consecutive cycles, no forwarding; source $0 never stalls.
- Jump in ID with a concurrent load-use stall -> flush_ifid=0 during the stall, 1 on the release cycle; flush_cnt=1. Force 2^CW+3 stalls -> stall_cnt saturates at 2^CW-1.
